keccak_perm_sched: RTL

- Shares one Keccak-f[1600] permutation datapath between NUM_REQ requesters (e.g. SHA3/SHAKE absorb and squeeze engines) using round-robin arbitration.
- Sequences the datapath's rounds by driving the round index that selects the iota constant, plus load, enable and last-round strobes.
- Returns a per-requester completion handshake; the result state stays held in the datapath until the requester consumes it.

---
 rtl/keccak_perm_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/keccak_perm_sched.sv
// keccak_perm_sched: round-robin scheduler sharing one Keccak-f[1600] permutation datapath between NUM_REQ requesters.
// Latency: a request accepted in cycle T runs rounds T+1..T+N (N = NUM_ROUNDS/ROUNDS_PER_CYCLE); rsp_valid is asserted from T+N+1.
// Backpressure: rsp_valid is held until rsp_ready[grant_id]; no new request is accepted until the scheduler is back in IDLE.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (req_ready one-hot, IDLE only)
//   rsp_valid/rsp_ready   per-requester completion handshake (rsp_valid one-hot)
//   grant_id              current datapath owner, drives the datapath in/out muxes
//   busy                  high whenever the scheduler is not IDLE
//   dp_load               datapath captures the granted requester's input state
//   dp_round_en           datapath applies ROUNDS_PER_CYCLE rounds this cycle
//   dp_round_idx          index of the first round applied this cycle (iota select)
//   dp_last_round         final enabled cycle of the permutation
// Optional: define KECCAK_PERM_SCHED_PERF_EN to add perf_clr, perm_count and stall_count.
module keccak_perm_sched #(
  parameter int NUM_REQ          = 2,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int NUM_ROUNDS       = 24,
  localparam int GW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               dp_load,
  output logic               dp_round_en,
  output logic [4:0]         dp_round_idx,
  output logic               dp_last_round
`ifdef KECCAK_PERM_SCHED_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [31:0]        perm_count,
  output logic [31:0]        stall_count
`endif
);

  // Elaboration-time parameter sanity
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("keccak_perm_sched: NUM_REQ must be in 1..8");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24) begin : g_bad_num_rounds
    $error("keccak_perm_sched: NUM_ROUNDS must be in 1..24");
  end
  if (ROUNDS_PER_CYCLE < 1 || (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
    $error("keccak_perm_sched: ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  // Keccak-p uses the last NUM_ROUNDS rounds of the full 24, so the index
  // always finishes at 24; the last enabled cycle starts at 24-RPC.
  localparam logic [4:0] START_IDX = 5'(24 - NUM_ROUNDS);
  localparam logic [4:0] LAST_IDX  = 5'(24 - ROUNDS_PER_CYCLE);
  localparam logic [4:0] RPC5      = 5'(ROUNDS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [GW-1:0]      arb_id;
  logic               arb_hit;
  logic [NUM_REQ-1:0] grant_oh;
  logic               rsp_hs;

  // Round-robin search starting just after the previous winner. Offset k is
  // the priority rank; the inner loop maps the rank back to a requester.
  always_comb begin
    arb_oh  = '0;
    arb_id  = '0;
    arb_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!arb_hit && req_valid[i] &&
            (i == ((int'(last_q) + 1 + k) % NUM_REQ))) begin
          arb_oh[i] = 1'b1;
          arb_id    = GW'(i);
          arb_hit   = 1'b1;
        end
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_q;
  // Only the owner's rsp_ready matters; the others are ignored.
  assign rsp_hs   = (state_q == RESP) && rsp_ready[grant_q];
  assign grant_id = grant_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    last_d        = last_q;
    req_ready     = '0;
    rsp_valid     = '0;
    dp_load       = 1'b0;
    dp_round_en   = 1'b0;
    dp_round_idx  = '0;
    dp_last_round = 1'b0;
    busy          = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        req_ready = arb_oh;
        if (arb_hit) begin
          dp_load = 1'b1;
          grant_d = arb_id;
          last_d  = arb_id;
          cnt_d   = START_IDX;
          state_d = ROUND;
        end
      end
      ROUND: begin
        dp_round_en   = 1'b1;
        dp_round_idx  = cnt_q;
        dp_last_round = (cnt_q == LAST_IDX);
        if (cnt_q == LAST_IDX) begin
          // Park the counter rather than stepping past 23.
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + RPC5;
        end
      end
      RESP: begin
        rsp_valid = grant_oh;
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_q resets to the top requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef KECCAK_PERM_SCHED_PERF_EN
  logic [31:0] perm_q, perm_d;
  logic [31:0] stall_q, stall_d;

  // Saturating counters; clear wins over increment.
  always_comb begin
    perm_d  = perm_q;
    stall_d = stall_q;
    if (perf_clr) begin
      perm_d  = '0;
      stall_d = '0;
    end else begin
      if (rsp_hs && (perm_q != 32'hFFFF_FFFF)) begin
        perm_d = perm_q + 32'd1;
      end
      if ((state_q == RESP) && !rsp_hs && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_q  <= '0;
      stall_q <= '0;
    end else begin
      perm_q  <= perm_d;
      stall_q <= stall_d;
    end
  end

  assign perm_count  = perm_q;
  assign stall_count = stall_q;
`endif

endmodule
